// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM encoding and address-byte layout.
package i2c_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned RW_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_WR_DATA  = 3'd3,
        ST_WR_ACK   = 3'd4,
        ST_RD_DATA  = 3'd5,
        ST_RD_ACK   = 3'd6,
        ST_WAIT     = 3'd7
    } state_e;

endpackage

// File: rtl/i2c_in_filter.sv
// Pad input conditioner: 2-FF synchroniser, FILT-deep glitch filter, registered edge pulses.
module i2c_in_filter #(
    parameter int unsigned FILT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad_i,
    output logic line_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CW = (FILT < 1) ? 1 : $clog2(FILT + 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          line_q, line_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    // Line flips only after FILT+1 consecutive samples disagree with it.
    always_comb begin
        sync_d = {sync_q[0], pad_i};
        cnt_d  = cnt_q;
        line_d = line_q;
        if (sync_q[1] == line_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(FILT)) begin
            line_d = sync_q[1];
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        rise_d = line_d & ~line_q;
        fall_d = ~line_d & line_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            line_q <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            line_q <= line_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign line_o = line_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/i2c_target.sv
// 7-bit-address I2C target presenting received bytes as strobes and requesting read bytes.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR = 7'h42,
    parameter int unsigned       FILT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       busy,
    output logic [7:0] wr_data,
    output logic       wr_first,
    output logic       wr_stb,
    output logic       rd_req,
    output logic       rd_first,
    input  logic [7:0] rd_data
);

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;
    logic scl_pre, start_c, stop_c;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]   shift_q, shift_d;
    logic [BYTE_W-1:0]   wr_data_q, wr_data_d;
    logic                byte_done_q, byte_done_d;
    logic                rw_q, rw_d;
    logic                first_q, first_d;
    logic                sda_oe_q, sda_oe_d;
    logic                busy_q, busy_d;
    logic                wr_first_q, wr_first_d;
    logic                wr_stb_q, wr_stb_d;
    logic                rd_req_q, rd_req_d;
    logic                rd_first_q, rd_first_d;

    i2c_in_filter #(.FILT(FILT)) u_scl_filt (
        .clk    (clk),
        .rst_n  (rst_n),
        .pad_i  (scl_i),
        .line_o (scl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_in_filter #(.FILT(FILT)) u_sda_filt (
        .clk    (clk),
        .rst_n  (rst_n),
        .pad_i  (sda_i),
        .line_o (sda),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    // SCL level just before any edge landing in this cycle qualifies SDA events.
    assign scl_pre = (scl & ~scl_rise) | scl_fall;
    assign start_c = sda_fall & scl_pre;
    assign stop_c  = sda_rise & scl_pre;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        wr_data_d   = wr_data_q;
        byte_done_d = byte_done_q;
        rw_d        = rw_q;
        first_d     = first_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_first_d  = wr_first_q;
        wr_stb_d    = 1'b0;
        rd_req_d    = 1'b0;
        rd_first_d  = rd_first_q;

        if (start_c) begin
            sda_oe_d    = 1'b0;
            bit_cnt_d   = '0;
            byte_done_d = 1'b0;
            state_d     = ST_ADDR;
        end else if (stop_c) begin
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
            byte_done_d = 1'b0;
            state_d     = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_ADDR, ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[BYTE_W-2:0], sda};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(BYTE_W - 1)) begin
                            byte_done_d = 1'b1;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        if (state_q == ST_ADDR) begin
                            // General call (all-zero address) is never acknowledged.
                            if (shift_q[BYTE_W-1:1] == ADDR && shift_q[BYTE_W-1:1] != '0) begin
                                sda_oe_d = 1'b1;
                                busy_d   = 1'b1;
                                rw_d     = shift_q[RW_BIT];
                                state_d  = ST_ADDR_ACK;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = ST_WAIT;
                            end
                        end else begin
                            wr_data_d  = shift_q;
                            wr_stb_d   = 1'b1;
                            wr_first_d = first_q;
                            first_d    = 1'b0;
                            sda_oe_d   = 1'b1;
                            state_d    = ST_WR_ACK;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (rw_q && scl_rise) begin
                        rd_req_d   = 1'b1;
                        rd_first_d = 1'b1;
                    end else if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (rw_q) begin
                            shift_d  = rd_data;
                            sda_oe_d = ~rd_data[BYTE_W-1];
                            state_d  = ST_RD_DATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            first_d  = 1'b1;
                            state_d  = ST_WR_DATA;
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_WR_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(BYTE_W - 1)) begin
                            byte_done_d = 1'b1;
                        end
                    end else if (scl_fall) begin
                        if (byte_done_q) begin
                            byte_done_d = 1'b0;
                            sda_oe_d    = 1'b0;
                            state_d     = ST_RD_ACK;
                        end else begin
                            shift_d  = {shift_q[BYTE_W-2:0], 1'b0};
                            sda_oe_d = ~shift_q[BYTE_W-2];
                        end
                    end
                end
                ST_RD_ACK: begin
                    // A NACK leaves immediately, so any fall seen here follows an ACK.
                    if (scl_rise) begin
                        if (!sda) begin
                            rd_req_d   = 1'b1;
                            rd_first_d = 1'b0;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = ST_WAIT;
                        end
                    end else if (scl_fall) begin
                        bit_cnt_d = '0;
                        shift_d   = rd_data;
                        sda_oe_d  = ~rd_data[BYTE_W-1];
                        state_d   = ST_RD_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            wr_data_q   <= '0;
            byte_done_q <= 1'b0;
            rw_q        <= 1'b0;
            first_q     <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_first_q  <= 1'b0;
            wr_stb_q    <= 1'b0;
            rd_req_q    <= 1'b0;
            rd_first_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            wr_data_q   <= wr_data_d;
            byte_done_q <= byte_done_d;
            rw_q        <= rw_d;
            first_q     <= first_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_first_q  <= wr_first_d;
            wr_stb_q    <= wr_stb_d;
            rd_req_q    <= rd_req_d;
            rd_first_q  <= rd_first_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign busy     = busy_q;
    assign wr_data  = wr_data_q;
    assign wr_first = wr_first_q;
    assign wr_stb   = wr_stb_q;
    assign rd_req   = rd_req_q;
    assign rd_first = rd_first_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bus-level master tasks on a wired-AND bus, strobe scoreboard monitor.
module tb_i2c_target;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl_oe = 1'b0;
    logic       m_sda_oe = 1'b0;
    logic [7:0] rd_data = 8'h00;
    logic       scl_i, sda_i;
    logic       sda_oe, busy, wr_first, wr_stb, rd_req, rd_first;
    logic [7:0] wr_data;

    assign sda_i = ~(m_sda_oe | sda_oe);
    assign scl_i = ~m_scl_oe;

    i2c_target #(.ADDR(7'h42), .FILT(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda_oe   (sda_oe),
        .busy     (busy),
        .wr_data  (wr_data),
        .wr_first (wr_first),
        .wr_stb   (wr_stb),
        .rd_req   (rd_req),
        .rd_first (rd_first),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       first;
    } wr_exp_t;

    wr_exp_t    exp_wr[$];
    logic       exp_rd_first[$];
    logic [7:0] rd_vals[$];
    int         checks = 0;
    int         errors = 0;
    int         n_wr = 0;
    int         n_rd = 0;
    logic       sda_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard plus fabric read-data responder.
    initial begin
        wr_exp_t e;
        logic    f;
        forever begin
            @(negedge clk);
            if (sda_oe) sda_seen = 1'b1;
            if (wr_stb) begin
                n_wr++;
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wr_stb: got wr_data=%0h, expected no strobe", wr_data);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_data", 32'(wr_data), 32'(e.data));
                    chk("wr_first", 32'(wr_first), 32'(e.first));
                    chk("wr_rd_exclusive", 32'(rd_req), 32'(0));
                end
            end
            if (rd_req) begin
                n_rd++;
                if (exp_rd_first.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rd_req: got rd_req=1, expected no request");
                end else begin
                    f = exp_rd_first.pop_front();
                    chk("rd_first", 32'(rd_first), 32'(f));
                end
                rd_data = (rd_vals.size() != 0) ? rd_vals.pop_front() : 8'h00;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic q_wait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic m_start();
        m_sda_oe = 1'b0; q_wait();
        m_scl_oe = 1'b0; q_wait();
        m_sda_oe = 1'b1; q_wait();
        m_scl_oe = 1'b1; q_wait();
    endtask

    task automatic m_stop();
        m_sda_oe = 1'b1; q_wait();
        m_scl_oe = 1'b0; q_wait();
        m_sda_oe = 1'b0; q_wait();
    endtask

    task automatic m_bit(input logic b, output logic s);
        m_sda_oe = ~b;   q_wait();
        m_scl_oe = 1'b0; q_wait();
        s = sda_i;       q_wait();
        m_scl_oe = 1'b1; q_wait();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) m_bit(b[i], s);
        m_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic ack_in, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            m_bit(1'b1, s);
            d[i] = s;
        end
        m_bit(ack_in, s);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         w0, r0;

        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_sda_oe", 32'(sda_oe), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_wr_stb", 32'(wr_stb), 32'(0));
        chk("reset_rd_req", 32'(rd_req), 32'(0));
        chk("reset_wr_data", 32'(wr_data), 32'(0));
        chk("reset_wr_first", 32'(wr_first), 32'(0));
        chk("reset_rd_first", 32'(rd_first), 32'(0));
        repeat (20) @(negedge clk);

        // Single-byte write
        w0 = n_wr;
        exp_wr.push_back('{data: 8'hA5, first: 1'b1});
        m_start();
        write_byte(8'h84, ack); chk("t1_addr_ack", 32'(ack), 32'(0));
        write_byte(8'hA5, ack); chk("t1_data_ack", 32'(ack), 32'(0));
        chk("t1_busy_active", 32'(busy), 32'(1));
        m_stop();
        repeat (20) @(negedge clk);
        chk("t1_busy_after_stop", 32'(busy), 32'(0));
        chk("t1_wr_count", 32'(n_wr - w0), 32'(1));

        // Wrong address
        w0 = n_wr; r0 = n_rd;
        sda_seen = 1'b0;
        m_start();
        write_byte(8'h86, ack); chk("t2_addr_nack", 32'(ack), 32'(1));
        m_stop();
        repeat (20) @(negedge clk);
        chk("t2_sda_never_driven", 32'(sda_seen), 32'(0));
        chk("t2_busy", 32'(busy), 32'(0));
        chk("t2_strobes", 32'((n_wr - w0) + (n_rd - r0)), 32'(0));

        // Two-byte read, ACK then NACK
        r0 = n_rd;
        exp_rd_first.push_back(1'b1); exp_rd_first.push_back(1'b0);
        rd_vals.push_back(8'h3C);     rd_vals.push_back(8'hC3);
        m_start();
        write_byte(8'h85, ack); chk("t3_addr_ack", 32'(ack), 32'(0));
        read_byte(1'b0, d);     chk("t3_data0", 32'(d), 32'h3C);
        read_byte(1'b1, d);     chk("t3_data1", 32'(d), 32'hC3);
        repeat (10) @(negedge clk);
        chk("t3_busy_after_nack", 32'(busy), 32'(0));
        m_stop();
        repeat (20) @(negedge clk);
        chk("t3_rd_count", 32'(n_rd - r0), 32'(2));

        // Write then repeated START into a read
        w0 = n_wr; r0 = n_rd;
        exp_wr.push_back('{data: 8'h11, first: 1'b1});
        exp_rd_first.push_back(1'b1);
        rd_vals.push_back(8'h5A);
        m_start();
        write_byte(8'h84, ack); chk("t4_waddr_ack", 32'(ack), 32'(0));
        write_byte(8'h11, ack); chk("t4_wdata_ack", 32'(ack), 32'(0));
        m_start();
        write_byte(8'h85, ack); chk("t4_raddr_ack", 32'(ack), 32'(0));
        read_byte(1'b1, d);     chk("t4_rdata", 32'(d), 32'h5A);
        m_stop();
        repeat (20) @(negedge clk);
        chk("t4_wr_count", 32'(n_wr - w0), 32'(1));
        chk("t4_rd_count", 32'(n_rd - r0), 32'(1));

        // Coincident FILT-clock glitch on both lines must not create a START
        sda_seen = 1'b0;
        m_scl_oe = 1'b1; m_sda_oe = 1'b1;
        repeat (2) @(negedge clk);
        m_scl_oe = 1'b0; m_sda_oe = 1'b0;
        repeat (20) @(negedge clk);
        chk("t5_busy", 32'(busy), 32'(0));
        chk("t5_sda_oe", 32'(sda_oe), 32'(0));
        m_scl_oe = 1'b1; q_wait();
        write_byte(8'h84, ack); chk("t5_no_start_nack", 32'(ack), 32'(1));
        chk("t5_sda_never_driven", 32'(sda_seen), 32'(0));
        m_stop();
        repeat (20) @(negedge clk);

        // Reset while the target drives a 0 bit of a read byte
        w0 = n_wr; r0 = n_rd;
        exp_rd_first.push_back(1'b1);
        rd_vals.push_back(8'h00);
        m_start();
        write_byte(8'h85, ack); chk("t6_addr_ack", 32'(ack), 32'(0));
        chk("t6_driving_zero", 32'(sda_oe), 32'(1));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_released_after_reset", 32'(sda_oe), 32'(0));
        sda_seen = 1'b0;
        read_byte(1'b1, d);     chk("t6_ignored_byte", 32'(d), 32'hFF);
        chk("t6_sda_quiet", 32'(sda_seen), 32'(0));
        m_stop();
        repeat (20) @(negedge clk);
        m_start();
        write_byte(8'h84, ack); chk("t6_readdress_ack", 32'(ack), 32'(0));
        m_stop();
        repeat (20) @(negedge clk);
        chk("t6_busy", 32'(busy), 32'(0));
        chk("t6_wr_count", 32'(n_wr - w0), 32'(0));
        chk("t6_rd_count", 32'(n_rd - r0), 32'(1));

        chk("exp_wr_drained", 32'(exp_wr.size()), 32'(0));
        chk("exp_rd_drained", 32'(exp_rd_first.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
